// File: rtl/dec_syndrome_calc.sv
// SECDED decoder front end: computes the Hamming syndrome and overall parity
// of a received codeword and classifies it as clean, single-error or
// double-error. Two registered stages with valid/ready backpressure, plus
// saturating error-event counters fed by the output handshake.
module dec_syndrome_calc #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] codeword,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] codeword_out,
    output logic [4:0]            whichColIsError,
    output logic                  err_single,
    output logic                  err_double,
    input  logic                  cnt_clear,
    output logic [CNT_WIDTH-1:0]  single_cnt,
    output logic [CNT_WIDTH-1:0]  double_cnt
);

    localparam int K  = $clog2(DATA_WIDTH);
    localparam int NB = DATA_WIDTH / 8;

    // Within one byte, syndrome bits 0..2 depend on the bit offset inside the
    // byte; syndrome bits 3 and up depend only on the byte index, so for those
    // the whole byte parity is enough. S1 therefore keeps three partial
    // parities plus one full parity per byte.
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_cw;
    logic [NB-1:0][2:0]    s1_part;
    logic [NB-1:0]         s1_bpar;

    logic [NB-1:0][2:0]    part_d;
    logic [NB-1:0]         bpar_d;
    logic [4:0]            syn;
    logic                  par;
    logic                  s1_adv;
    logic                  s2_adv;

    // Handshake: each stage advances when its successor can take its content.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    // Per-byte partial parities of the incoming codeword.
    always_comb begin
        part_d = '0;
        bpar_d = '0;
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < 8; j++) begin
                bpar_d[b] = bpar_d[b] ^ codeword[8*b+j];
                for (int k = 0; k < 3; k++) begin
                    if (((j >> k) & 1) != 0) begin
                        part_d[b][k] = part_d[b][k] ^ codeword[8*b+j];
                    end
                end
            end
        end
    end

    // Stage 1 register: codeword and partial parities.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_part  <= '0;
            s1_bpar  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cw   <= codeword;
                s1_part <= part_d;
                s1_bpar <= bpar_d;
            end
        end
    end

    // Fold the per-byte partials into the syndrome and overall parity.
    always_comb begin
        syn = '0;
        par = ^s1_bpar;
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < NB; b++) begin
                syn[k] = syn[k] ^ s1_part[b][k];
            end
        end
        for (int k = 3; k < 5; k++) begin
            if (k < K) begin
                for (int b = 0; b < NB; b++) begin
                    if (((b >> (k - 3)) & 1) != 0) begin
                        syn[k] = syn[k] ^ s1_bpar[b];
                    end
                end
            end
        end
    end

    // Stage 2 register: syndrome, classification and forwarded codeword.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid       <= 1'b0;
            codeword_out    <= '0;
            whichColIsError <= '0;
            err_single      <= 1'b0;
            err_double      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                codeword_out    <= s1_cw;
                whichColIsError <= syn;
                err_single      <= par;
                err_double      <= !par && (syn != 5'd0);
            end
        end
    end

    // Error-event counters: count results as they are accepted downstream,
    // saturate at all-ones, clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            single_cnt <= '0;
            double_cnt <= '0;
        end else if (cnt_clear) begin
            single_cnt <= '0;
            double_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (err_single && (single_cnt != {CNT_WIDTH{1'b1}})) begin
                single_cnt <= single_cnt + 1'b1;
            end
            if (err_double && (double_cnt != {CNT_WIDTH{1'b1}})) begin
                double_cnt <= double_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dec_syndrome_calc.sv
// Bench for dec_syndrome_calc: an 8-bit instance for the pipeline, stall,
// clear and reset behaviour, and a 32-bit instance with 2-bit counters for
// the wide syndrome and counter saturation.
module tb_dec_syndrome_calc;

    typedef struct packed {
        logic [31:0] cw;
        logic [4:0]  col;
        logic        sgl;
        logic        dbl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, sgl8, dbl8, clr8;
    logic [7:0]  cw8, cwo8;
    logic [4:0]  col8;
    logic [15:0] scnt8, dcnt8;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, sgl32, dbl32, clr32;
    logic [31:0] cw32, cwo32;
    logic [4:0]  col32;
    logic [1:0]  scnt32, dcnt32;

    dec_syndrome_calc #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .codeword(cw8), .out_valid(out_valid8), .out_ready(out_ready8),
        .codeword_out(cwo8), .whichColIsError(col8), .err_single(sgl8),
        .err_double(dbl8), .cnt_clear(clr8), .single_cnt(scnt8), .double_cnt(dcnt8)
    );

    dec_syndrome_calc #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .codeword(cw32), .out_valid(out_valid32), .out_ready(out_ready32),
        .codeword_out(cwo32), .whichColIsError(col32), .err_single(sgl32),
        .err_double(dbl32), .cnt_clear(clr32), .single_cnt(scnt32), .double_cnt(dcnt32)
    );

    int checks = 0;
    int fails  = 0;

    exp_t sb8[$];
    exp_t sb32[$];
    logic [15:0] es8 = '0, ed8 = '0;
    logic [1:0]  es32 = '0, ed32 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: syndrome is the XOR of the positions of all set bits.
    function automatic exp_t model(input logic [31:0] cw, input int w);
        exp_t       e;
        logic [4:0] s;
        logic       p;
        s = '0;
        p = 1'b0;
        for (int i = 0; i < w; i++) begin
            if (cw[i]) begin
                p = ~p;
                s = s ^ 5'(i);
            end
        end
        e.cw  = cw;
        e.col = s;
        e.sgl = p;
        e.dbl = !p && (s != 5'd0);
        return e;
    endfunction

    // Scoreboard and counter model for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        logic hs;
        hs = 1'b0;
        e  = '0;
        if (!rst) begin
            es8 = '0;
            ed8 = '0;
        end
        check("single_cnt8", 32'(scnt8), 32'(es8));
        check("double_cnt8", 32'(dcnt8), 32'(ed8));
        if (rst && out_valid8 && out_ready8) begin
            if (sb8.size() == 0) begin
                checks++;
                fails++;
                $error("FAIL sb8_unexpected: observed output 0x%0h expected none", cwo8);
            end else begin
                e  = sb8.pop_front();
                hs = 1'b1;
                check("codeword_out8", 32'(cwo8), e.cw);
                check("col8", 32'(col8), 32'(e.col));
                check("err_single8", 32'(sgl8), 32'(e.sgl));
                check("err_double8", 32'(dbl8), 32'(e.dbl));
            end
        end
        if (clr8) begin
            es8 = '0;
            ed8 = '0;
        end else if (hs) begin
            if (e.sgl && es8 != 16'hffff) es8 = es8 + 16'd1;
            if (e.dbl && ed8 != 16'hffff) ed8 = ed8 + 16'd1;
        end
    end

    // Scoreboard and counter model for the 32-bit instance.
    always @(negedge clk) begin
        exp_t e;
        logic hs;
        hs = 1'b0;
        e  = '0;
        if (!rst) begin
            es32 = '0;
            ed32 = '0;
        end
        check("single_cnt32", 32'(scnt32), 32'(es32));
        check("double_cnt32", 32'(dcnt32), 32'(ed32));
        if (rst && out_valid32 && out_ready32) begin
            if (sb32.size() == 0) begin
                checks++;
                fails++;
                $error("FAIL sb32_unexpected: observed output 0x%0h expected none", cwo32);
            end else begin
                e  = sb32.pop_front();
                hs = 1'b1;
                check("codeword_out32", cwo32, e.cw);
                check("col32", 32'(col32), 32'(e.col));
                check("err_single32", 32'(sgl32), 32'(e.sgl));
                check("err_double32", 32'(dbl32), 32'(e.dbl));
            end
        end
        if (clr32) begin
            es32 = '0;
            ed32 = '0;
        end else if (hs) begin
            if (e.sgl && es32 != 2'b11) es32 = es32 + 2'd1;
            if (e.dbl && ed32 != 2'b11) ed32 = ed32 + 2'd1;
        end
    end

    task automatic send8(input logic [7:0] cw);
        logic acc;
        in_valid8 = 1'b1;
        cw8       = cw;
        sb8.push_back(model(32'(cw), 8));
        acc = 1'b0;
        for (int n = 0; n < 60 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready8;
            @(posedge clk);
            #1;
        end
        in_valid8 = 1'b0;
        check("send8_accepted", 32'(acc), 32'd1);
    endtask

    task automatic send32(input logic [31:0] cw);
        logic acc;
        in_valid32 = 1'b1;
        cw32       = cw;
        sb32.push_back(model(cw, 32));
        acc = 1'b0;
        for (int n = 0; n < 60 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready32;
            @(posedge clk);
            #1;
        end
        in_valid32 = 1'b0;
        check("send32_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain8();
        for (int n = 0; n < 100 && sb8.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain8", 32'(sb8.size()), 32'd0);
    endtask

    task automatic drain32();
        for (int n = 0; n < 100 && sb32.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain32", 32'(sb32.size()), 32'd0);
    endtask

    initial begin
        in_valid8  = 1'b0; cw8  = '0; out_ready8  = 1'b1; clr8  = 1'b0;
        in_valid32 = 1'b0; cw32 = '0; out_ready32 = 1'b1; clr32 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_codeword_out", 32'(cwo8), 32'd0);
        check("rst_col", 32'(col8), 32'd0);
        check("rst_err_single", 32'(sgl8), 32'd0);
        check("rst_err_double", 32'(dbl8), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready8), 32'd1);
        @(posedge clk);
        #1;

        // Clean word, two-cycle latency
        send8(8'h00);
        @(negedge clk);
        check("latency_cycle1", 32'(out_valid8), 32'd0);
        @(negedge clk);
        check("latency_cycle2", 32'(out_valid8), 32'd1);
        check("clean_col", 32'(col8), 32'd0);
        drain8();

        // Single error in bit 3
        send8(8'h08);
        drain8();
        check("single_cnt_after_08", 32'(scnt8), 32'd1);

        // Single error in parity bit, then double error
        send8(8'h01);
        send8(8'h18);
        drain8();
        check("single_cnt_after_01", 32'(scnt8), 32'd2);
        check("double_cnt_after_18", 32'(dcnt8), 32'd1);

        // Back-to-back random words at full throughput
        for (int i = 0; i < 6; i++) send8(8'($urandom_range(0, 255)));
        drain8();

        // Backpressure: four words against a stalled output
        out_ready8 = 1'b0;
        fork
            begin
                send8(8'h03);
                send8(8'h05);
                send8(8'h18);
                send8(8'h80);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", 32'(in_ready8), 32'd0);
                check("stall_out_valid", 32'(out_valid8), 32'd1);
                check("stall_cw_a", 32'(cwo8), 32'h03);
                @(negedge clk);
                check("stall_in_ready_hold", 32'(in_ready8), 32'd0);
                check("stall_cw_hold", 32'(cwo8), 32'h03);
                check("stall_col_hold", 32'(col8), 32'd1);
                check("stall_dbl_hold", 32'(dbl8), 32'd1);
                @(posedge clk);
                #1 out_ready8 = 1'b1;
            end
        join
        drain8();

        // Clear beats a same-cycle increment
        out_ready8 = 1'b0;
        send8(8'h08);
        repeat (2) @(posedge clk);
        #1;
        check("held_before_clear", 32'(out_valid8), 32'd1);
        clr8       = 1'b1;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1 clr8 = 1'b0;
        check("clear_priority_single", 32'(scnt8), 32'd0);
        check("clear_priority_double", 32'(dcnt8), 32'd0);
        drain8();

        // Wide codeword: top column and saturation of 2-bit counters
        send32(32'h8000_0000);
        send32(32'h8000_0002);
        drain32();
        check("wide_double_cnt", 32'(dcnt32), 32'd1);
        send32(32'h0000_0020);
        send32(32'h0001_0000);
        send32(32'h0000_0001);
        send32(32'h4000_0000);
        drain32();
        check("wide_single_saturated", 32'(scnt32), 32'd3);

        // Reset with two words in flight
        send8(8'h08);
        drain8();
        out_ready8 = 1'b0;
        send8(8'h10);
        send8(8'h20);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid8), 32'd0);
        check("midrst_single_cnt", 32'(scnt8), 32'd0);
        check("midrst_double_cnt", 32'(dcnt8), 32'd0);
        sb8.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready8 = 1'b1;
        send8(8'h00);
        @(negedge clk);
        check("post_rst_latency1", 32'(out_valid8), 32'd0);
        @(negedge clk);
        check("post_rst_latency2", 32'(out_valid8), 32'd1);
        drain8();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
